// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: multi-cycle initiator between execute and the CSR file.
// Handles one Zicsr / ECALL / MRET request at a time: latches it, sequences
// the CSR read-modify-write or trap/return traffic, then presents a response
// holding the old CSR value and any PC redirect until the consumer takes it.
module csr_access_ctrl #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] ECALL_CAUSE = DATA_WIDTH'(11)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [11:0]           req_csr,
  input  logic [DATA_WIDTH-1:0] req_src,
  input  logic                  req_src_x0,
  input  logic [DATA_WIDTH-1:0] req_pc,
  output logic [11:0]           csr_raddr,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  csr_we,
  output logic [11:0]           csr_waddr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_redirect,
  output logic [DATA_WIDTH-1:0] rsp_target,
  output logic                  rsp_illegal
);

  localparam logic [2:0]  OP_CSRRW = 3'b001;
  localparam logic [2:0]  OP_CSRRS = 3'b010;
  localparam logic [2:0]  OP_CSRRC = 3'b011;
  localparam logic [2:0]  OP_ECALL = 3'b100;
  localparam logic [2:0]  OP_MRET  = 3'b101;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    EPC,
    CAUSE,
    VEC,
    RESP
  } state_t;

  state_t state, next_state;

  logic [2:0]            op_q;
  logic [11:0]           csr_q;
  logic [DATA_WIDTH-1:0] src_q;
  logic                  src_x0_q;
  logic [DATA_WIDTH-1:0] pc_q;

  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [DATA_WIDTH-1:0] rsp_target_q;
  logic                  rsp_redirect_q;
  logic                  rsp_illegal_q;

  logic accept;
  logic in_zicsr;
  logic in_known;
  logic in_csr_supported;
  logic in_csr_readonly;
  logic in_writes;
  logic in_illegal;
  logic q_set_clear;

  // Classify the incoming request so the IDLE decision and latched flags agree.
  always_comb begin
    in_zicsr         = (req_op == OP_CSRRW) || (req_op == OP_CSRRS) || (req_op == OP_CSRRC);
    in_known         = in_zicsr || (req_op == OP_ECALL) || (req_op == OP_MRET);
    in_csr_readonly  = (req_csr == CSR_MVENDORID) || (req_csr == CSR_MARCHID);
    in_csr_supported = in_csr_readonly || (req_csr == CSR_MSTATUS) || (req_csr == CSR_MTVEC) ||
                       (req_csr == CSR_MEPC) || (req_csr == CSR_MCAUSE);
    in_writes        = (req_op == OP_CSRRW) || !req_src_x0;
    in_illegal       = !in_known ||
                       (in_zicsr && (!in_csr_supported || (in_csr_readonly && in_writes)));
    q_set_clear      = (op_q == OP_CSRRS) || (op_q == OP_CSRRC);
  end

  assign accept = req_valid && req_ready;

  // State register; reset parks the machine in IDLE straight away.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus every port the current state drives.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    csr_raddr  = 12'h000;
    csr_we     = 1'b0;
    csr_waddr  = 12'h000;
    csr_wdata  = '0;
    case (state)
      IDLE: begin
        // reset is active-low, so this keeps ready low while reset is held
        req_ready = reset;
        if (accept) begin
          if (in_illegal) begin
            next_state = RESP;
          end else if (in_zicsr) begin
            next_state = RD;
          end else if (req_op == OP_ECALL) begin
            next_state = EPC;
          end else begin
            next_state = VEC;
          end
        end
      end
      RD: begin
        csr_raddr = csr_q;
        if (q_set_clear && src_x0_q) begin
          next_state = RESP;
        end else begin
          next_state = WR;
        end
      end
      WR: begin
        csr_we    = 1'b1;
        csr_waddr = csr_q;
        case (op_q)
          OP_CSRRS: csr_wdata = rsp_rdata_q | src_q;
          OP_CSRRC: csr_wdata = rsp_rdata_q & ~src_q;
          default:  csr_wdata = src_q;
        endcase
        next_state = RESP;
      end
      EPC: begin
        csr_we     = 1'b1;
        csr_waddr  = CSR_MEPC;
        csr_wdata  = pc_q;
        next_state = CAUSE;
      end
      CAUSE: begin
        csr_we     = 1'b1;
        csr_waddr  = CSR_MCAUSE;
        csr_wdata  = ECALL_CAUSE;
        next_state = VEC;
      end
      VEC: begin
        csr_raddr  = (op_q == OP_ECALL) ? CSR_MTVEC : CSR_MEPC;
        next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the request on acceptance and build up the response fields as the sequence runs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q           <= 3'b000;
      csr_q          <= 12'h000;
      src_q          <= '0;
      src_x0_q       <= 1'b0;
      pc_q           <= '0;
      rsp_rdata_q    <= '0;
      rsp_target_q   <= '0;
      rsp_redirect_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q           <= req_op;
            csr_q          <= req_csr;
            src_q          <= req_src;
            src_x0_q       <= req_src_x0;
            pc_q           <= req_pc;
            rsp_rdata_q    <= '0;
            rsp_target_q   <= '0;
            rsp_redirect_q <= 1'b0;
            rsp_illegal_q  <= in_illegal;
          end
        end
        RD: begin
          rsp_rdata_q <= csr_rdata;
        end
        VEC: begin
          rsp_redirect_q <= 1'b1;
          rsp_target_q   <= (op_q == OP_ECALL) ? (csr_rdata & ~DATA_WIDTH'(3)) : csr_rdata;
        end
        default: begin
        end
      endcase
    end
  end

  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_target   = rsp_target_q;
  assign rsp_redirect = rsp_redirect_q;
  assign rsp_illegal  = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: drives csr_access_ctrl against a small CSR register
// file and checks every response, latency and CSR write against a
// transaction-level model of the machine-mode CSRs.
module tb_csr_access_ctrl;

  localparam int DW = 32;
  localparam logic [31:0] MVENDORID_VAL = 32'h0000_0489;
  localparam logic [31:0] MARCHID_VAL   = 32'd23060025;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'b000;
  logic [11:0]   req_csr = 12'h000;
  logic [DW-1:0] req_src = '0;
  logic          req_src_x0 = 1'b0;
  logic [DW-1:0] req_pc = '0;
  logic [11:0]   csr_raddr;
  logic [DW-1:0] csr_rdata;
  logic          csr_we;
  logic [11:0]   csr_waddr;
  logic [DW-1:0] csr_wdata;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_redirect;
  logic [DW-1:0] rsp_target;
  logic          rsp_illegal;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  csr_access_ctrl #(.DATA_WIDTH(DW), .ECALL_CAUSE(32'd11)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_csr(req_csr),
    .req_src(req_src), .req_src_x0(req_src_x0), .req_pc(req_pc),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_redirect(rsp_redirect), .rsp_target(rsp_target), .rsp_illegal(rsp_illegal)
  );

  // CSR register file seen by the DUT, with a log of every write it receives
  logic [31:0] f_mstatus, f_mtvec, f_mepc, f_mcause;
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = 12'h000;
  logic [31:0] pre_val = '0;
  int          wr_cnt = 0;
  logic [11:0] wr_a [0:1023];
  logic [31:0] wr_d [0:1023];

  // Combinational read port of the CSR file
  always_comb begin
    case (csr_raddr)
      12'h300: csr_rdata = f_mstatus;
      12'h305: csr_rdata = f_mtvec;
      12'h341: csr_rdata = f_mepc;
      12'h342: csr_rdata = f_mcause;
      12'hF11: csr_rdata = MVENDORID_VAL;
      12'hF12: csr_rdata = MARCHID_VAL;
      default: csr_rdata = 32'h0;
    endcase
  end

  // Write port of the CSR file plus the bench's backdoor preload path
  always @(posedge clock) begin
    if (csr_we) begin
      wr_a[wr_cnt % 1024] <= csr_waddr;
      wr_d[wr_cnt % 1024] <= csr_wdata;
      wr_cnt <= wr_cnt + 1;
      case (csr_waddr)
        12'h300: f_mstatus <= csr_wdata;
        12'h305: f_mtvec   <= csr_wdata;
        12'h341: f_mepc    <= csr_wdata;
        12'h342: f_mcause  <= csr_wdata;
        default: begin end
      endcase
    end else if (pre_en) begin
      case (pre_addr)
        12'h300: f_mstatus <= pre_val;
        12'h305: f_mtvec   <= pre_val;
        12'h341: f_mepc    <= pre_val;
        12'h342: f_mcause  <= pre_val;
        default: begin end
      endcase
    end
  end

  // Architectural model of the machine-mode CSRs
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hF11: return MVENDORID_VAL;
      12'hF12: return MARCHID_VAL;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] v);
    case (a)
      12'h300: m_mstatus = v;
      12'h305: m_mtvec   = v;
      12'h341: m_mepc    = v;
      12'h342: m_mcause  = v;
      default: begin end
    endcase
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    @(negedge clock);
    pre_en = 1'b1; pre_addr = a; pre_val = v;
    @(posedge clock);
    #1 pre_en = 1'b0;
    m_write(a, v);
  endtask

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_req_ready"}, {31'b0, req_ready}, 32'h0);
    check_output({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
    check_output({tag, "_csr_we"}, {31'b0, csr_we}, 32'h0);
    check_output({tag, "_raddr"}, {20'b0, csr_raddr}, 32'h0);
    check_output({tag, "_waddr"}, {20'b0, csr_waddr}, 32'h0);
    check_output({tag, "_wdata"}, csr_wdata, 32'h0);
    check_output({tag, "_rdata"}, rsp_rdata, 32'h0);
    check_output({tag, "_redirect"}, {31'b0, rsp_redirect}, 32'h0);
    check_output({tag, "_target"}, rsp_target, 32'h0);
    check_output({tag, "_illegal"}, {31'b0, rsp_illegal}, 32'h0);
  endtask

  // One full request/response transaction checked against the CSR model
  task automatic apply_stimulus(input logic [2:0] op, input logic [11:0] csr, input logic [31:0] src,
                                input logic x0, input logic [31:0] pc, input int stall);
    logic        zicsr, known, sup, ro, wr, ill, e_redir;
    logic [31:0] old, nv, e_rdata, e_target;
    logic [11:0] e_wa [2];
    logic [31:0] e_wd [2];
    int          e_lat, e_nw, base, lat;
    bit          done;
    zicsr = (op == 3'b001) || (op == 3'b010) || (op == 3'b011);
    known = zicsr || (op == 3'b100) || (op == 3'b101);
    ro    = (csr == 12'hF11) || (csr == 12'hF12);
    sup   = ro || (csr == 12'h300) || (csr == 12'h305) || (csr == 12'h341) || (csr == 12'h342);
    wr    = (op == 3'b001) || !x0;
    ill   = !known || (zicsr && (!sup || (ro && wr)));
    e_rdata = 32'h0; e_target = 32'h0; e_redir = 1'b0; e_lat = 1; e_nw = 0;
    e_wa[0] = '0; e_wa[1] = '0; e_wd[0] = '0; e_wd[1] = '0;
    if (!ill) begin
      if (zicsr) begin
        old = m_read(csr);
        case (op)
          3'b010:  nv = old | src;
          3'b011:  nv = old & ~src;
          default: nv = src;
        endcase
        e_rdata = old;
        if (wr) begin
          e_lat = 3; e_nw = 1; e_wa[0] = csr; e_wd[0] = nv;
          m_write(csr, nv);
        end else begin
          e_lat = 2;
        end
      end else if (op == 3'b100) begin
        e_lat = 4; e_nw = 2;
        e_wa[0] = 12'h341; e_wd[0] = pc;
        e_wa[1] = 12'h342; e_wd[1] = 32'd11;
        m_mepc = pc; m_mcause = 32'd11;
        e_redir = 1'b1; e_target = m_mtvec & ~32'h3;
      end else begin
        e_lat = 2; e_redir = 1'b1; e_target = m_mepc;
      end
    end

    @(negedge clock);
    base = wr_cnt;
    req_op = op; req_csr = csr; req_src = src; req_src_x0 = x0; req_pc = pc;
    req_valid = 1'b1;
    check_output("req_ready_idle", {31'b0, req_ready}, 32'h1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_op = 3'($urandom); req_csr = 12'($urandom); req_src = $urandom;
    req_src_x0 = 1'($urandom); req_pc = $urandom;

    lat = 0; done = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
      if (rsp_valid) done = 1'b1;
    end
    if (!done) begin
      check_output("rsp_timeout", {31'b0, rsp_valid}, 32'h1);
      reset_dut();
      return;
    end
    check_output("latency", lat, e_lat);
    check_output("rsp_rdata", rsp_rdata, e_rdata);
    check_output("rsp_redirect", {31'b0, rsp_redirect}, {31'b0, e_redir});
    check_output("rsp_illegal", {31'b0, rsp_illegal}, {31'b0, ill});
    if (e_redir) check_output("rsp_target", rsp_target, e_target);
    check_output("req_ready_busy", {31'b0, req_ready}, 32'h0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      check_output("stall_valid", {31'b0, rsp_valid}, 32'h1);
      check_output("stall_rdata", rsp_rdata, e_rdata);
      check_output("stall_redirect", {31'b0, rsp_redirect}, {31'b0, e_redir});
      check_output("stall_illegal", {31'b0, rsp_illegal}, {31'b0, ill});
      if (e_redir) check_output("stall_target", rsp_target, e_target);
      check_output("stall_req_ready", {31'b0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    @(negedge clock);
    check_output("post_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check_output("post_req_ready", {31'b0, req_ready}, 32'h1);
    check_output("write_count", wr_cnt - base, e_nw);
    for (int i = 0; i < e_nw && i < 2; i++) begin
      check_output("write_addr", {20'b0, wr_a[(base + i) % 1024]}, {20'b0, e_wa[i]});
      check_output("write_data", wr_d[(base + i) % 1024], e_wd[i]);
    end
  endtask

  initial begin
    logic [11:0] csr_pick [8];
    int base;
    csr_pick = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hF11, 12'hF12, 12'h7C0, 12'h000};

    $display("[TB] reset checks");
    #1 reset = 1'b0;
    #2;
    check_reset_outputs("reset");
    preload(12'h300, 32'h0000_1800);
    preload(12'h305, 32'h8000_0100);
    preload(12'h341, 32'h0);
    preload(12'h342, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1 check_output("ready_after_reset", {31'b0, req_ready}, 32'h1);

    $display("[TB] directed transactions");
    apply_stimulus(3'b001, 12'h305, 32'h8000_0200, 1'b0, 32'h0, 5);
    apply_stimulus(3'b010, 12'h300, 32'h0000_0008, 1'b0, 32'h0, 0);
    apply_stimulus(3'b011, 12'h300, 32'h0000_1000, 1'b0, 32'h0, 0);
    apply_stimulus(3'b010, 12'h300, 32'h0000_0000, 1'b1, 32'h0, 1);
    apply_stimulus(3'b011, 12'h300, 32'h0000_0000, 1'b1, 32'h0, 0);
    preload(12'h305, 32'h8000_0103);
    apply_stimulus(3'b100, 12'h000, 32'h0, 1'b0, 32'h8000_0040, 2);
    preload(12'h341, 32'h8000_0044);
    apply_stimulus(3'b101, 12'h000, 32'h0, 1'b0, 32'h0, 0);
    apply_stimulus(3'b001, 12'hF11, 32'h1234, 1'b0, 32'h0, 0);
    apply_stimulus(3'b010, 12'h7C0, 32'h1, 1'b0, 32'h0, 0);
    apply_stimulus(3'b111, 12'h300, 32'h1, 1'b0, 32'h0, 0);
    apply_stimulus(3'b010, 12'hF12, 32'h0, 1'b1, 32'h0, 0);

    $display("[TB] reset during CAUSE");
    preload(12'h305, 32'h8000_0200);
    @(negedge clock);
    base = wr_cnt;
    req_op = 3'b100; req_csr = 12'h0; req_src = 32'h0; req_src_x0 = 1'b0; req_pc = 32'h8000_0080;
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check_output("epc_waddr", {20'b0, csr_waddr}, 32'h341);
    @(negedge clock);
    check_output("cause_waddr", {20'b0, csr_waddr}, 32'h342);
    check_output("cause_wdata", csr_wdata, 32'd11);
    reset = 1'b0;
    #1 check_reset_outputs("abort");
    m_mepc = 32'h8000_0080;
    @(negedge clock);
    reset = 1'b1;
    #1 check_output("abort_ready", {31'b0, req_ready}, 32'h1);
    check_output("abort_write_count", wr_cnt - base, 32'd1);
    apply_stimulus(3'b001, 12'h342, 32'h5, 1'b0, 32'h0, 0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 60; t++) begin
      logic [2:0]  op;
      logic [11:0] csr;
      logic        x0;
      op  = 3'($urandom_range(0, 7));
      csr = csr_pick[$urandom_range(0, 7)];
      if (csr == 12'h000) csr = 12'($urandom);
      x0  = ($urandom_range(0, 3) == 0);
      apply_stimulus(op, csr, x0 ? 32'h0 : $urandom, x0, $urandom & ~32'h3, $urandom_range(0, 3));
    end

    check_output("final_mstatus", f_mstatus, m_mstatus);
    check_output("final_mtvec", f_mtvec, m_mtvec);
    check_output("final_mepc", f_mepc, m_mepc);
    check_output("final_mcause", f_mcause, m_mcause);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
